// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb_pkg
//  Description : Shared types and widths for the shared-multiplier arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;
    localparam int NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

endpackage : mult_arb_pkg
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter_if
//  Description : Requester, response and multiplier-side signals of the
//                shared-multiplier arbiter. The slave modport is the arbiter
//                view; the master modport is the surrounding-logic view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if;
    import mult_arb_pkg::*;

    // requester side
    logic [NREQ-1:0]  req;
    logic [OP_W-1:0]  x0;
    logic [OP_W-1:0]  y0;
    logic [OP_W-1:0]  x1;
    logic [OP_W-1:0]  y1;
    logic [NREQ-1:0]  ack;

    // response side
    logic             rsp_valid;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_res;
    logic             rsp_err;
    logic             busy;

    // multiplier side
    logic [OP_W-1:0]  mul_x;
    logic [OP_W-1:0]  mul_y;
    logic             mul_start;
    logic             mul_rst;
    logic             mul_done;
    logic [RES_W-1:0] mul_res;

    modport slave (
        input  req, x0, y0, x1, y1, mul_done, mul_res,
        output ack, rsp_valid, rsp_id, rsp_res, rsp_err, busy,
               mul_x, mul_y, mul_start, mul_rst
    );

    modport master (
        output req, x0, y0, x1, y1, mul_done, mul_res,
        input  ack, rsp_valid, rsp_id, rsp_res, rsp_err, busy,
               mul_x, mul_y, mul_start, mul_rst
    );

endinterface : mult_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant logic, purely combinational. The
//                last-grant pointer register lives in the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mult_arb_pkg::*;
(
    input  wire logic [NREQ-1:0] req_i,
    input  wire logic            last_i,
    output logic      [NREQ-1:0] gnt_o,
    output logic                 last_nxt_o
);

    // Single request wins outright; a tie goes to whoever was not granted last.
    always_comb begin
        gnt_o      = 2'b00;
        last_nxt_o = last_i;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o != 2'b00) begin
            last_nxt_o = gnt_o[1];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Shares one 8-bit multiplier between two requesters. Grants
//                round-robin, pulses start, waits for DONE, returns the
//                tagged product and resets the multiplier control unit.
//                Optional WAIT-state abort: define MULT_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int TIMEOUT = 32
)
(
    input  wire logic     clk,
    input  wire logic     RESET,
    mult_arbiter_if.slave bus
);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q;
    logic [OP_W-1:0]  mul_x_q, mul_y_q;
    logic             rsp_id_q;
    logic [RES_W-1:0] rsp_res_q;

    logic [NREQ-1:0]  gnt;
    logic             ld_op;
    logic             ld_rsp;

    rr_arbiter2 u_rr (
        .req_i      (bus.req),
        .last_i     (last_q),
        .gnt_o      (gnt),
        .last_nxt_o (last_d)
    );

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt_q;
    logic       rsp_err_q;
    logic       ld_tmo;
    logic       tmo_hit;

    assign tmo_hit = (tmo_cnt_q == C_TMO_LAST);

    // WAIT-cycle counter: zeroed while launching, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (RESET) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == LAUNCH) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    // Error flag follows whichever way the WAIT state was left.
    always_ff @(posedge clk) begin
        if (RESET) begin
            rsp_err_q <= 1'b0;
        end else if (ld_rsp) begin
            rsp_err_q <= 1'b0;
        end else if (ld_tmo) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; DONE only matters in WAIT, where it beats expiry.
    always_comb begin
        state_d = state_q;
        ld_op   = 1'b0;
        ld_rsp  = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        ld_tmo  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    ld_op   = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (bus.mul_done) begin
                    ld_rsp  = 1'b1;
                    state_d = CLEAR;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    ld_tmo  = 1'b1;
                    state_d = CLEAR;
                end
`endif
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on grant and result capture on leaving WAIT.
    always_ff @(posedge clk) begin
        if (RESET) begin
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            mul_x_q   <= '0;
            mul_y_q   <= '0;
            rsp_id_q  <= 1'b0;
            rsp_res_q <= '0;
        end else begin
            if (ld_op) begin
                last_q  <= last_d;
                owner_q <= gnt[1];
                mul_x_q <= gnt[1] ? bus.x1 : bus.x0;
                mul_y_q <= gnt[1] ? bus.y1 : bus.y0;
            end
            if (ld_rsp) begin
                rsp_res_q <= bus.mul_res;
                rsp_id_q  <= owner_q;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (ld_tmo) begin
                rsp_res_q <= '0;
                rsp_id_q  <= owner_q;
            end
`endif
        end
    end

    assign bus.ack       = (state_q == LAUNCH) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.mul_start = (state_q == LAUNCH);
    assign bus.rsp_valid = (state_q == CLEAR);
    // Multiplier control is also held in reset for every RESET cycle.
    assign bus.mul_rst   = RESET | (state_q == CLEAR);
    assign bus.busy      = (state_q != IDLE);
    assign bus.mul_x     = mul_x_q;
    assign bus.mul_y     = mul_y_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Directed self-checking bench for mult_arbiter with a simple
//                behavioural multiplier (DONE a set number of cycles after
//                start, held until mul_rst). Timeout cases need
//                MULT_ARB_TIMEOUT_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    mult_arbiter_if mif ();

    // behavioural multiplier state
    logic        m_done     = 1'b0;
    logic        m_act      = 1'b0;
    logic        m_never    = 1'b0;
    logic        force_done = 1'b0;
    logic [15:0] m_res      = 16'h0;
    int          m_cnt      = 0;
    int          m_lat      = 3;

    int n_vec = 0;
    int n_bad = 0;

    assign mif.mul_done = m_done | force_done;
    assign mif.mul_res  = m_res;

    mult_arbiter #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (mif)
    );

    // Multiplier model, evaluated on the falling edge so it never races the DUT.
    always @(negedge clk) begin
        if (mif.mul_rst) begin
            m_done = 1'b0;
            m_act  = 1'b0;
        end else if (mif.mul_start) begin
            m_act = 1'b1;
            m_cnt = m_lat;
        end else if (m_act && !m_done && !m_never) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else begin
                m_done = 1'b1;
                m_res  = {8'h00, mif.mul_x} * {8'h00, mif.mul_y};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (mif.ack == 2'b00 && cyc < 30);
        if (mif.ack == 2'b00) chk("ack_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output int cyc, output int starts);
        cyc    = 0;
        starts = 0;
        do begin
            tick();
            cyc++;
            if (mif.mul_start) starts++;
        end while (!mif.rsp_valid && cyc < 300);
        if (!mif.rsp_valid) chk("rsp_wait", 32'd0, 32'd1);
    endtask

    // One request from one requester, checked from grant through to response.
    task automatic do_single(input logic id, input logic [7:0] x, input logic [7:0] y,
                             input int lat, input logic [15:0] exp_res,
                             input logic exp_err, input int exp_lat);
        int c;
        int s;
        m_lat = lat;
        if (id) begin
            mif.x1 = x; mif.y1 = y; mif.req = 2'b10;
        end else begin
            mif.x0 = x; mif.y0 = y; mif.req = 2'b01;
        end
        wait_ack(c);
        chk("ack",       {30'd0, mif.ack}, id ? 32'd2 : 32'd1);
        chk("mul_start", {31'd0, mif.mul_start}, 32'd1);
        chk("mul_x",     {24'd0, mif.mul_x}, {24'd0, x});
        chk("mul_y",     {24'd0, mif.mul_y}, {24'd0, y});
        mif.req = 2'b00;
        wait_rsp(c, s);
        chk("rsp_id",    {31'd0, mif.rsp_id}, {31'd0, id});
        chk("rsp_res",   {16'd0, mif.rsp_res}, {16'd0, exp_res});
        chk("rsp_err",   {31'd0, mif.rsp_err}, {31'd0, exp_err});
        chk("mul_rst",   {31'd0, mif.mul_rst}, 32'd1);
        chk("latency",   c, exp_lat);
        chk("extra_start", s, 0);
        tick();
        chk("busy_after", {31'd0, mif.busy}, 32'd0);
        chk("valid_once", {31'd0, mif.rsp_valid}, 32'd0);
        chk("res_held",   {16'd0, mif.rsp_res}, {16'd0, exp_res});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int s;
        RESET   = 1'b1;
        mif.req = 2'b00;
        mif.x0  = 8'h00; mif.y0 = 8'h00;
        mif.x1  = 8'h00; mif.y1 = 8'h00;

        // reset state
        tick();
        tick();
        chk("rst_mul_rst",   {31'd0, mif.mul_rst}, 32'd1);
        chk("rst_busy",      {31'd0, mif.busy}, 32'd0);
        chk("rst_ack",       {30'd0, mif.ack}, 32'd0);
        chk("rst_valid",     {31'd0, mif.rsp_valid}, 32'd0);
        chk("rst_err",       {31'd0, mif.rsp_err}, 32'd0);
        chk("rst_start",     {31'd0, mif.mul_start}, 32'd0);
        chk("rst_res",       {16'd0, mif.rsp_res}, 32'd0);
        chk("rst_id",        {31'd0, mif.rsp_id}, 32'd0);
        chk("rst_mul_x",     {24'd0, mif.mul_x}, 32'd0);
        chk("rst_mul_y",     {24'd0, mif.mul_y}, 32'd0);
        RESET = 1'b0;
        tick();
        chk("idle_mul_rst",  {31'd0, mif.mul_rst}, 32'd0);

        // single request, DONE ten cycles after start: 0x0F * 0x11 = 0x00FF
        do_single(1'b0, 8'h0F, 8'h11, 10, 16'h00FF, 1'b0, 11);

        // contention straight out of reset: requester 0 wins the first tie
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        m_lat = 3;
        mif.x0 = 8'h03; mif.y0 = 8'h05;
        mif.x1 = 8'hFF; mif.y1 = 8'hFF;
        mif.req = 2'b11;
        wait_ack(c);
        chk("tie_ack0", {30'd0, mif.ack}, 32'd1);
        mif.req = 2'b10;
        wait_rsp(c, s);
        chk("tie_id0",  {31'd0, mif.rsp_id}, 32'd0);
        chk("tie_res0", {16'd0, mif.rsp_res}, 32'h000F);
        tick();
        chk("gap_busy", {31'd0, mif.busy}, 32'd0);
        chk("gap_ack",  {30'd0, mif.ack}, 32'd0);
        tick();
        chk("tie_ack1", {30'd0, mif.ack}, 32'd2);
        chk("tie_start1", {31'd0, mif.mul_start}, 32'd1);
        mif.req = 2'b00;
        wait_rsp(c, s);
        chk("tie_id1",  {31'd0, mif.rsp_id}, 32'd1);
        chk("tie_res1", {16'd0, mif.rsp_res}, 32'hFE01);
        tick();

        // edge operands
        do_single(1'b1, 8'h00, 8'hAB, 3, 16'h0000, 1'b0, 4);
        do_single(1'b0, 8'h80, 8'h02, 3, 16'h0100, 1'b0, 4);

        // reset while waiting for DONE; the held request is served afterwards
        m_lat = 20;
        mif.x0 = 8'h21; mif.y0 = 8'h03;
        mif.req = 2'b01;
        wait_ack(c);
        tick();
        tick();
        tick();
        RESET = 1'b1;
        tick();
        chk("midrst_mul_rst", {31'd0, mif.mul_rst}, 32'd1);
        chk("midrst_valid",   {31'd0, mif.rsp_valid}, 32'd0);
        chk("midrst_busy",    {31'd0, mif.busy}, 32'd0);
        RESET = 1'b0;
        m_lat = 3;
        wait_ack(c);
        chk("regrant_ack",  {30'd0, mif.ack}, 32'd1);
        chk("regrant_cyc",  c, 1);
        mif.req = 2'b00;
        wait_rsp(c, s);
        chk("regrant_res",  {16'd0, mif.rsp_res}, 32'h0063);
        chk("regrant_lat",  c, 4);
        tick();

        // stray DONE in IDLE and LAUNCH is ignored
        force_done = 1'b1;
        tick();
        tick();
        chk("stray_busy",  {31'd0, mif.busy}, 32'd0);
        chk("stray_valid", {31'd0, mif.rsp_valid}, 32'd0);
        m_lat = 3;
        mif.x0 = 8'h07; mif.y0 = 8'h09;
        mif.req = 2'b01;
        wait_ack(c);
        chk("stray_ack", {30'd0, mif.ack}, 32'd1);
        force_done = 1'b0;
        mif.req = 2'b00;
        wait_rsp(c, s);
        chk("stray_res", {16'd0, mif.rsp_res}, 32'h003F);
        chk("stray_lat", c, 4);
        tick();

`ifdef MULT_ARB_TIMEOUT_EN
        // TIMEOUT = 8: abort after eight WAIT cycles
        m_never = 1'b1;
        do_single(1'b0, 8'h05, 8'h06, 3, 16'h0000, 1'b1, 9);
        // DONE arriving on the expiry cycle wins
        m_never = 1'b0;
        do_single(1'b0, 8'h05, 8'h06, 8, 16'h001E, 1'b0, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mult_arbiter
`default_nettype wire
